mux_arb_n_x1: RTL and testbench

- Parametrised N-to-1 data multiplexer with built-in arbitration and a valid/ready handshake on every input and on the output.
- Replaces the static select-driven 4:1 mux wherever several producers share one consumer, e.g. writeback result sources or memory request sources in the MIPS datapath.
- The select is generated internally by a fixed-priority or round-robin arbiter.
- The result is held in a one-entry output register, giving 1-cycle latency and full throughput.

---
 rtl/mux_arb_n_x1_if.sv | 36 +++
 rtl/mux_arb_n_x1.sv | 88 ++++++++
 tb/tb_mux_arb_n_x1.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_arb_n_x1_if.sv
// Handshake bundle for mux_arb_n_x1: N request channels in, one registered channel out.
// slave is the arbiter's view, master the producers'/consumer's view.
interface mux_arb_n_x1_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_INPUTS = 4
);
    localparam int unsigned SEL_WIDTH = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    logic [NUM_INPUTS-1:0]            i_valid;
    logic [NUM_INPUTS*DATA_WIDTH-1:0] i_data;
    logic [NUM_INPUTS-1:0]            o_ready;
    logic                             o_valid;
    logic [DATA_WIDTH-1:0]            o_data;
    logic [SEL_WIDTH-1:0]             o_sel;
    logic                             i_ready;

    modport slave (
        input  i_valid,
        input  i_data,
        input  i_ready,
        output o_ready,
        output o_valid,
        output o_data,
        output o_sel
    );

    modport master (
        output i_valid,
        output i_data,
        output i_ready,
        input  o_ready,
        input  o_valid,
        input  o_data,
        input  o_sel
    );
endinterface

// File: rtl/mux_arb_n_x1.sv
// N-to-1 arbitrated multiplexer with valid/ready on every side and a one-entry output register.
// Fixed-priority (lowest index) or round-robin grant; one transfer per cycle while downstream is ready.
module mux_arb_n_x1 #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_INPUTS = 4,
    parameter int unsigned RR_MODE    = 1
) (
    input logic           i_clk,
    input logic           i_rst,
    mux_arb_n_x1_if.slave bus
);
    localparam int unsigned SEL_WIDTH = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam logic [SEL_WIDTH:0]   NumIn   = (SEL_WIDTH + 1)'(NUM_INPUTS);
    localparam logic [SEL_WIDTH-1:0] LastIdx = SEL_WIDTH'(NUM_INPUTS - 1);

    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [SEL_WIDTH-1:0]  sel_q;
    logic [SEL_WIDTH-1:0]  ptr_q;
    logic [SEL_WIDTH-1:0]  ptr_d;

    logic                  load;
    logic                  found;
    logic                  xfer_in;
    logic [SEL_WIDTH-1:0]  start;
    logic [SEL_WIDTH-1:0]  win;
    logic [SEL_WIDTH:0]    cand;
    logic [DATA_WIDTH-1:0] win_data;

    // Search upward from the start index with wrap; the extra bit keeps start+offset exact.
    always_comb begin
        start    = (RR_MODE != 0) ? ptr_q : '0;
        found    = 1'b0;
        win      = '0;
        cand     = '0;
        win_data = '0;
        for (int unsigned off = 0; off < NUM_INPUTS; off++) begin
            cand = {1'b0, start} + (SEL_WIDTH + 1)'(off);
            if (cand >= NumIn) begin
                cand = cand - NumIn;
            end
            if (!found && bus.i_valid[cand[SEL_WIDTH-1:0]]) begin
                found = 1'b1;
                win   = cand[SEL_WIDTH-1:0];
            end
        end
        for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
            if (win == SEL_WIDTH'(k)) begin
                win_data = bus.i_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign load    = !valid_q || bus.i_ready;
    assign xfer_in = load && found;
    assign ptr_d   = (win == LastIdx) ? '0 : win + 1'b1;

    // Reset gates the grant so o_ready falls together with the held word.
    always_comb begin
        bus.o_ready = '0;
        if (xfer_in && !i_rst) begin
            bus.o_ready[win] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else if (xfer_in) begin
            valid_q <= 1'b1;
            data_q  <= win_data;
            sel_q   <= win;
            if (RR_MODE != 0) begin
                ptr_q <= ptr_d;
            end
        end else if (valid_q && bus.i_ready) begin
            // Word consumed with nothing to replace it; data and index stay as last loaded.
            valid_q <= 1'b0;
        end
    end

    assign bus.o_valid = valid_q;
    assign bus.o_data  = data_q;
    assign bus.o_sel   = sel_q;
endmodule

// File: tb/tb_mux_arb_n_x1.sv
// Bench for mux_arb_n_x1: round-robin N=4, fixed-priority N=4 and round-robin N=3 instances
// driven by directed steps then random traffic, checked against a queue-free behavioural model.
module tb_mux_arb_n_x1;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_arb_n_x1_if #(.DATA_WIDTH(32), .NUM_INPUTS(4)) bus_rr ();
    mux_arb_n_x1_if #(.DATA_WIDTH(32), .NUM_INPUTS(4)) bus_fp ();
    mux_arb_n_x1_if #(.DATA_WIDTH(32), .NUM_INPUTS(3)) bus_w3 ();

    mux_arb_n_x1 #(.DATA_WIDTH(32), .NUM_INPUTS(4), .RR_MODE(1)) dut_rr (
        .i_clk(clk), .i_rst(rst), .bus(bus_rr));
    mux_arb_n_x1 #(.DATA_WIDTH(32), .NUM_INPUTS(4), .RR_MODE(0)) dut_fp (
        .i_clk(clk), .i_rst(rst), .bus(bus_fp));
    mux_arb_n_x1 #(.DATA_WIDTH(32), .NUM_INPUTS(3), .RR_MODE(1)) dut_w3 (
        .i_clk(clk), .i_rst(rst), .bus(bus_w3));

    // Stimulus per instance: 0 = rr4, 1 = fp4, 2 = rr3
    logic [3:0]  tv [3];
    logic [31:0] td [3][4];
    logic        tr [3];

    assign bus_rr.i_valid = tv[0];
    assign bus_rr.i_data  = {td[0][3], td[0][2], td[0][1], td[0][0]};
    assign bus_rr.i_ready = tr[0];
    assign bus_fp.i_valid = tv[1];
    assign bus_fp.i_data  = {td[1][3], td[1][2], td[1][1], td[1][0]};
    assign bus_fp.i_ready = tr[1];
    assign bus_w3.i_valid = tv[2][2:0];
    assign bus_w3.i_data  = {td[2][2], td[2][1], td[2][0]};
    assign bus_w3.i_ready = tr[2];

    // Reference model state
    int          n  [3] = '{4, 4, 3};
    bit          rr [3] = '{1'b1, 1'b0, 1'b1};
    logic        m_valid [3];
    logic [31:0] m_data  [3];
    int          m_sel   [3];
    int          m_ptr   [3];

    int passed = 0;
    int failed = 0;
    int total  = 0;

    int rr_sel_exp [6] = '{0, 1, 2, 3, 0, 1};
    int w3_sel_exp [4] = '{0, 2, 0, 2};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int winner(input int i);
        int start;
        int k;
        start = rr[i] ? m_ptr[i] : 0;
        for (int off = 0; off < n[i]; off++) begin
            k = (start + off) % n[i];
            if (tv[i][k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready(input int i);
        int w;
        logic [3:0] one;
        one = 4'b0001;
        w = winner(i);
        if (rst) return 4'b0000;
        if ((!m_valid[i] || tr[i]) && w >= 0) return one << w;
        return 4'b0000;
    endfunction

    task automatic model_edge();
        int w;
        for (int i = 0; i < 3; i++) begin
            w = winner(i);
            if ((!m_valid[i] || tr[i]) && w >= 0) begin
                m_valid[i] = 1'b1;
                m_data[i]  = td[i][w];
                m_sel[i]   = w;
                if (rr[i]) m_ptr[i] = (w + 1) % n[i];
            end else if (m_valid[i] && tr[i]) begin
                m_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_valid[i] = 1'b0;
            m_data[i]  = '0;
            m_sel[i]   = 0;
            m_ptr[i]   = 0;
        end
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 3; i++) begin
            tv[i] = '0;
            tr[i] = 1'b1;
            for (int k = 0; k < 4; k++) td[i][k] = '0;
        end
    endtask

    task automatic get(input int i, output logic ov, output logic [31:0] od,
                       output logic [3:0] os, output logic [3:0] ordy);
        case (i)
            0: begin ov = bus_rr.o_valid; od = bus_rr.o_data;
                     os = {2'b00, bus_rr.o_sel}; ordy = bus_rr.o_ready; end
            1: begin ov = bus_fp.o_valid; od = bus_fp.o_data;
                     os = {2'b00, bus_fp.o_sel}; ordy = bus_fp.o_ready; end
            default: begin ov = bus_w3.o_valid; od = bus_w3.o_data;
                     os = {2'b00, bus_w3.o_sel}; ordy = {1'b0, bus_w3.o_ready}; end
        endcase
    endtask

    task automatic check_ready();
        logic ov; logic [31:0] od; logic [3:0] os; logic [3:0] ordy;
        for (int i = 0; i < 3; i++) begin
            get(i, ov, od, os, ordy);
            chk($sformatf("ready[%0d]", i), 64'(ordy), 64'(exp_ready(i)));
        end
    endtask

    task automatic check_regs();
        logic ov; logic [31:0] od; logic [3:0] os; logic [3:0] ordy;
        for (int i = 0; i < 3; i++) begin
            get(i, ov, od, os, ordy);
            chk($sformatf("o_valid[%0d]", i), 64'(ov), 64'(m_valid[i]));
            chk($sformatf("o_data[%0d]", i), 64'(od), 64'(m_data[i]));
            chk($sformatf("o_sel[%0d]", i), 64'(os), 64'(m_sel[i]));
        end
    endtask

    // Entered shortly after a rising edge with inputs applied; returns 1 time unit after the next.
    task automatic cycle();
        #2;
        check_ready();
        @(posedge clk);
        model_edge();
        #1;
        check_regs();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_ready();
        check_regs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        model_reset();

        // Reset then idle
        pulse_reset();
        repeat (5) begin
            cycle();
            chk("idle_valid", 64'(bus_rr.o_valid), 64'(0));
            chk("idle_data", 64'(bus_rr.o_data), 64'(0));
            chk("idle_sel", 64'(bus_rr.o_sel), 64'(0));
            chk("idle_ready", 64'(bus_rr.o_ready), 64'(0));
        end

        // Single channel
        tv[0] = 4'b0100;
        td[0][2] = 32'hDEADBEEF;
        #1;
        chk("single_ready", 64'(bus_rr.o_ready), 64'(4'b0100));
        cycle();
        chk("single_valid", 64'(bus_rr.o_valid), 64'(1));
        chk("single_data", 64'(bus_rr.o_data), 64'(32'hDEADBEEF));
        chk("single_sel", 64'(bus_rr.o_sel), 64'(2));
        tv[0] = 4'b0000;
        cycle();
        chk("single_drain", 64'(bus_rr.o_valid), 64'(0));

        // Round-robin fairness and fixed priority side by side
        clear_inputs();
        pulse_reset();
        tv[0] = 4'b1111;
        tv[1] = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            td[0][k] = 32'(k + 1);
            td[1][k] = 32'h100 + 32'(k);
        end
        for (int c = 0; c < 6; c++) begin
            cycle();
            chk("rr_valid", 64'(bus_rr.o_valid), 64'(1));
            chk("rr_sel", 64'(bus_rr.o_sel), 64'(rr_sel_exp[c]));
            chk("rr_data", 64'(bus_rr.o_data), 64'(rr_sel_exp[c] + 1));
            if (c < 3) begin
                chk("fp_sel", 64'(bus_fp.o_sel), 64'(1));
                chk("fp_data", 64'(bus_fp.o_data), 64'(32'h101));
            end
        end

        // Backpressure
        clear_inputs();
        pulse_reset();
        for (int i = 0; i < 2; i++) begin
            tv[i] = 4'b0001;
            td[i][0] = 32'hA0;
            td[i][1] = 32'hA1;
        end
        cycle();
        tv[0] = 4'b0011; tv[1] = 4'b0011;
        tr[0] = 1'b0;    tr[1] = 1'b0;
        repeat (3) begin
            #1;
            chk("bp_ready_rr", 64'(bus_rr.o_ready), 64'(0));
            chk("bp_ready_fp", 64'(bus_fp.o_ready), 64'(0));
            cycle();
            chk("bp_hold_sel", 64'(bus_rr.o_sel), 64'(0));
            chk("bp_hold_data", 64'(bus_rr.o_data), 64'(32'hA0));
            chk("bp_hold_valid", 64'(bus_rr.o_valid), 64'(1));
        end
        tr[0] = 1'b1; tr[1] = 1'b1;
        #1;
        chk("bp_rel_ready_rr", 64'(bus_rr.o_ready), 64'(4'b0010));
        chk("bp_rel_ready_fp", 64'(bus_fp.o_ready), 64'(4'b0001));
        cycle();
        chk("bp_rel_valid_rr", 64'(bus_rr.o_valid), 64'(1));
        chk("bp_rel_sel_rr", 64'(bus_rr.o_sel), 64'(1));
        chk("bp_rel_data_rr", 64'(bus_rr.o_data), 64'(32'hA1));
        chk("bp_rel_sel_fp", 64'(bus_fp.o_sel), 64'(0));

        // Wrap on three channels, then asynchronous reset between edges
        clear_inputs();
        pulse_reset();
        tv[2] = 4'b0101;
        for (int k = 0; k < 3; k++) td[2][k] = 32'hC0 + 32'(k);
        for (int c = 0; c < 4; c++) begin
            cycle();
            chk("wrap_sel", 64'(bus_w3.o_sel), 64'(w3_sel_exp[c]));
            chk("wrap_valid", 64'(bus_w3.o_valid), 64'(1));
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_valid", 64'(bus_w3.o_valid), 64'(0));
        chk("async_data", 64'(bus_w3.o_data), 64'(0));
        chk("async_ready", 64'(bus_w3.o_ready), 64'(0));
        #1;
        rst = 1'b0;
        tv[2] = 4'b0110;
        cycle();
        chk("post_reset_sel", 64'(bus_w3.o_sel), 64'(1));
        chk("post_reset_valid", 64'(bus_w3.o_valid), 64'(1));

        // Random traffic with random downstream stalls
        clear_inputs();
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < 3; i++) begin
                tv[i] = 4'($urandom_range(0, 15));
                if (n[i] == 3) tv[i][3] = 1'b0;
                tr[i] = ($urandom_range(0, 3) != 0);
                for (int k = 0; k < 4; k++) td[i][k] = $urandom;
            end
            cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
